// File: rtl/fetch_pkg.sv
// Shared types and helpers for the picoMIPS fetch sequencer.
package fetch_pkg;

  localparam int PA_WIDTH_DEF = 4;
  // Widest program address the branch helper supports.
  localparam int PA_MAX = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    HALT    = 3'd4
  } state_t;

  // Callers truncate the result to their own address width, so the add wraps modulo 2^width.
  function automatic logic [PA_MAX-1:0] next_pc(input logic [PA_MAX-1:0] pc,
                                                input logic [PA_MAX-1:0] off);
    return pc + off;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Program counter and fetch sequencer driving the combinational program memory.
//
// state   | meaning
// IDLE    | after reset, PC=0, waiting for start
// RUN     | executing one instruction per cycle
// WAIT_HI | waiting for ext_ready to go high
// WAIT_LO | waiting for ext_ready to go low again
// HALT    | stopped, PC held, start restarts from 0
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int PA_WIDTH = PA_WIDTH_DEF,
  parameter bit WRAP     = 1'b1
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic                start,
  input  logic                halt_req,
  input  logic                wait_req,
  input  logic                jump,
  input  logic [PA_WIDTH-1:0] jump_addr,
  input  logic                branch,
  input  logic [PA_WIDTH-1:0] branch_off,
  input  logic                ext_ready,
  output logic [PA_WIDTH-1:0] address,
  output logic                instr_valid,
  output logic                ext_ack,
  output logic                halted
);

  state_t              state, state_nxt;
  logic [PA_WIDTH-1:0] pc, pc_nxt;
  logic                ack_nxt;
  logic                at_max;

  assign at_max = &pc;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ack_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (halt_req) begin
          state_nxt = HALT;
        end else if (wait_req) begin
          state_nxt = WAIT_HI;
        end else if (jump) begin
          pc_nxt = jump_addr;
        end else if (branch) begin
          pc_nxt = PA_WIDTH'(next_pc(PA_MAX'(pc), PA_MAX'($signed(branch_off))));
        end else if (at_max && !WRAP) begin
          state_nxt = HALT;
        end else begin
          pc_nxt = pc + PA_WIDTH'(1);
        end
      end
      WAIT_HI: begin
        if (ext_ready) state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (!ext_ready) begin
          ack_nxt = 1'b1;
          // Resuming past the last address follows the same wrap rule as a plain increment.
          if (at_max && !WRAP) begin
            state_nxt = HALT;
          end else begin
            state_nxt = RUN;
            pc_nxt    = pc + PA_WIDTH'(1);
          end
        end
      end
      HALT: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        pc_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      pc      <= '0;
      ext_ack <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      ext_ack <= ack_nxt;
    end
  end

  assign address     = pc;
  assign instr_valid = (state == RUN);
  assign halted      = (state == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and randomized checks of fetch_ctrl (WRAP=1 and WRAP=0) against a behavioural model.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       start = 1'b0, halt_req = 1'b0, wait_req = 1'b0, jump = 1'b0, branch = 1'b0;
  logic [3:0] jump_addr = '0, branch_off = '0;
  logic       ext_ready = 1'b0;

  logic [3:0] addr_w, addr_n;
  logic       valid_w, valid_n, ack_w, ack_n, halted_w, halted_n;

  int total = 0;
  int bad = 0;

  // Model modes: 0 idle, 1 running, 2 waiting for high, 3 waiting for low, 4 halted.
  int  mw_mode = 0, mw_pc = 0, mn_mode = 0, mn_pc = 0;
  bit  mw_ack = 0, mn_ack = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.PA_WIDTH(4), .WRAP(1'b1)) u_wrap (
    .clk(clk), .n_reset(n_reset), .start(start), .halt_req(halt_req), .wait_req(wait_req),
    .jump(jump), .jump_addr(jump_addr), .branch(branch), .branch_off(branch_off),
    .ext_ready(ext_ready), .address(addr_w), .instr_valid(valid_w), .ext_ack(ack_w),
    .halted(halted_w));

  fetch_ctrl #(.PA_WIDTH(4), .WRAP(1'b0)) u_nowrap (
    .clk(clk), .n_reset(n_reset), .start(start), .halt_req(halt_req), .wait_req(wait_req),
    .jump(jump), .jump_addr(jump_addr), .branch(branch), .branch_off(branch_off),
    .ext_ready(ext_ready), .address(addr_n), .instr_valid(valid_n), .ext_ack(ack_n),
    .halted(halted_n));

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mstep(input bit wrap, inout int mode, inout int pc, inout bit ack);
    int off;
    ack = 0;
    case (mode)
      0: if (start) mode = 1;
      1: begin
        if (halt_req) mode = 4;
        else if (wait_req) mode = 2;
        else if (jump) pc = int'(jump_addr);
        else if (branch) begin
          off = (branch_off >= 8) ? int'(branch_off) - 16 : int'(branch_off);
          pc = (pc + off + 16) % 16;
        end
        else if (pc == 15 && !wrap) mode = 4;
        else pc = (pc + 1) % 16;
      end
      2: if (ext_ready) mode = 3;
      3: if (!ext_ready) begin
        ack = 1;
        if (pc == 15 && !wrap) mode = 4;
        else begin
          mode = 1;
          pc = (pc + 1) % 16;
        end
      end
      default: if (start) begin
        mode = 1;
        pc = 0;
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".w.addr"},   32'(addr_w),   32'(mw_pc));
    cmp({tag, ".w.valid"},  32'(valid_w),  32'(mw_mode == 1));
    cmp({tag, ".w.ack"},    32'(ack_w),    32'(mw_ack));
    cmp({tag, ".w.halted"}, 32'(halted_w), 32'(mw_mode == 4));
    cmp({tag, ".n.addr"},   32'(addr_n),   32'(mn_pc));
    cmp({tag, ".n.valid"},  32'(valid_n),  32'(mn_mode == 1));
    cmp({tag, ".n.ack"},    32'(ack_n),    32'(mn_ack));
    cmp({tag, ".n.halted"}, 32'(halted_n), 32'(mn_mode == 4));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    mstep(1'b1, mw_mode, mw_pc, mw_ack);
    mstep(1'b0, mn_mode, mn_pc, mn_ack);
    #1;
    check_all(tag);
  endtask

  task automatic clear_inputs();
    start = 0; halt_req = 0; wait_req = 0; jump = 0; branch = 0; ext_ready = 0;
    jump_addr = '0; branch_off = '0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    mw_mode = 0; mw_pc = 0; mw_ack = 0;
    mn_mode = 0; mn_pc = 0; mn_ack = 0;
    check_all(tag);
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic goto_pc(input int target);
    @(negedge clk);
    clear_inputs();
    jump = 1; jump_addr = 4'(target);
    step("goto");
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    do_reset("reset");

    // Plain increment through the whole address space.
    @(negedge clk); start = 1;
    step("start");
    @(negedge clk); start = 0;
    for (int i = 0; i < 18; i++) step("incr");
    cmp("wrap_addr", 32'(addr_w), 32'(2));
    cmp("nowrap_halt_addr", 32'(addr_n), 32'(15));
    cmp("nowrap_halted", 32'(halted_n), 32'(1));

    @(negedge clk); start = 1;
    step("restart_nowrap");
    @(negedge clk); start = 0;

    goto_pc(5);
    branch = 1; branch_off = 4'b1110;
    step("br_back");
    cmp("br_back_addr", 32'(addr_w), 32'(3));

    goto_pc(14);
    branch = 1; branch_off = 4'd4;
    step("br_wrap");
    cmp("br_wrap_addr", 32'(addr_w), 32'(2));

    goto_pc(7);
    jump = 1; jump_addr = 4'd12; branch = 1; branch_off = 4'd3;
    step("jump_vs_br");
    cmp("jump_vs_br_addr", 32'(addr_w), 32'(12));

    goto_pc(4);
    wait_req = 1;
    step("wait_enter");
    @(negedge clk); wait_req = 0;
    for (int i = 0; i < 5; i++) step("wait_hi");
    cmp("wait_hold_addr", 32'(addr_w), 32'(4));
    cmp("wait_hold_valid", 32'(valid_w), 32'(0));
    @(negedge clk); ext_ready = 1;
    for (int i = 0; i < 3; i++) step("wait_lo");
    @(negedge clk); ext_ready = 0;
    step("hs_done");
    cmp("hs_addr", 32'(addr_w), 32'(5));
    cmp("hs_ack", 32'(ack_w), 32'(1));
    cmp("hs_valid", 32'(valid_w), 32'(1));
    step("hs_after");
    cmp("hs_ack_drop", 32'(ack_w), 32'(0));

    goto_pc(9);
    halt_req = 1;
    step("halt_enter");
    @(negedge clk); halt_req = 0;
    for (int i = 0; i < 10; i++) step("halt_hold");
    cmp("halt_addr", 32'(addr_w), 32'(9));
    cmp("halt_flag", 32'(halted_w), 32'(1));
    @(negedge clk); start = 1;
    step("halt_restart");
    @(negedge clk); start = 0;
    cmp("restart_addr", 32'(addr_w), 32'(0));
    cmp("restart_valid", 32'(valid_w), 32'(1));

    goto_pc(2);
    wait_req = 1;
    step("wait2_enter");
    @(negedge clk); wait_req = 0; ext_ready = 1;
    step("wait2_lo");
    do_reset("async_reset");
    cmp("async_reset_addr", 32'(addr_w), 32'(0));
    clear_inputs();

    // Randomized mix of decoder requests and handshake activity.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start      = ($urandom_range(7) == 0);
      halt_req   = ($urandom_range(15) == 0);
      wait_req   = ($urandom_range(7) == 0);
      jump       = ($urandom_range(7) == 0);
      branch     = ($urandom_range(3) == 0);
      jump_addr  = 4'($urandom_range(15));
      branch_off = 4'($urandom_range(15));
      ext_ready  = ($urandom_range(1) == 1);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
